clock_enable_generator: RTL and testbench
=========================================

# clock_enable_generator

Parametrised clock-enable and reset sequencer for the S/PDIF receiver's recovered clock domain. It sits directly behind the clock-recovery PLL and does two jobs. It holds a power-up reset for a fixed number of cycles after reset release. It then produces CHANNELS independent single-cycle enable strobes with run-time programmable divisors. Downstream logic runs on the one fast clock and qualifies on these strobes, instead of using separate divided clocks or toggle registers.

## Interface
Parameters:
- CHANNELS, 2: number of enable outputs (1..16).
- DIV_WIDTH, 16: width of each divisor and counter.
- POWERUP_CYCLES, 1024: cycles the power-up reset is held after reset release (≥1).
- DEFAULT_DIV, 2: divisor loaded into every channel at reset.

Ports:
- Clk  in  1  single clock, all logic on rising edge.
- nReset  in  1  reset, synchronous, active-low.
- Div_Load  in  1  one-cycle request to program a divisor.
- Div_Channel  in  max(1,$clog2(CHANNELS))  target channel of Div_Load.
- Div_Value  in  DIV_WIDTH  new divisor.
- Div_Ack  out  1  one-cycle pulse when a programmed divisor takes effect.
- Rec_Reset  out  1  active-high power-up reset for downstream logic.
- Ena  out  CHANNELS  per-channel enable strobes.
- Sync  in  1  phase-align request (only with CLOCK_ENABLE_SYNC_EN).

## Operation
- The block has two states.
  - HOLD (entered on reset): the power-up counter increments each cycle. Rec_Reset=1, Ena=0, and the channel counters are held at 0.
  - RUN: entered when the power-up counter reaches POWERUP_CYCLES. The block stays in RUN until nReset is next asserted.
- In RUN, channel i's counter counts 0..D[i]-1 and then wraps.
  - Ena[i]=1 for exactly the cycle in which the counter equals D[i]-1; otherwise Ena[i]=0.
  - D[i]=0 or D[i]=1 is treated as 1, so Ena[i] is held high continuously in RUN.
- Divisor programming:
  - Div_Load=1 with Div_Channel<CHANNELS writes Div_Value into the shadow register for that channel and sets its pending flag.
  - Div_Load with Div_Channel≥CHANNELS is ignored: no state change and no ack.
  - In RUN, a pending shadow value is copied to D[i] on the cycle the channel wraps (counter==D[i]-1). This keeps the switch glitch-free: the current period completes with the old divisor.
  - In HOLD, a pending shadow value is copied on the next cycle.
  - Div_Ack pulses on the cycle after each copy.
  - If several channels copy on the same cycle, one Div_Ack pulse covers all of them.
  - A new Div_Load to a channel that is already pending overwrites the shadow value. Only one ack is produced, and it is for the last value written.
  - A Div_Load on the same cycle as that channel's wrap does not take effect at that wrap. It takes effect at the following wrap.
- Arithmetic: counters are unsigned DIV_WIDTH-bit. A divisor of 2^DIV_WIDTH-1 is the maximum period.
- Reset mid-operation (nReset sampled low in any state) takes effect on the next edge:
  - return to HOLD with Rec_Reset=1;
  - counters cleared and Ena=0;
  - D[i] restored to DEFAULT_DIV;
  - pending flags cleared and Div_Ack=0.

## Timing
- Reset values: Rec_Reset=1, Ena=0, Div_Ack=0, D[i]=DEFAULT_DIV.
- Power-up release: nReset is first sampled high at edge k. Rec_Reset falls after edge k+POWERUP_CYCLES.
- Strobe timing: the first RUN cycle counts as cycle 1. Ena[i] is high in cycles n·D[i] for n≥1.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Divisor latency:
  - In RUN: Div_Ack comes 1 cycle after the wrap that applies the new divisor.
  - In HOLD: Div_Ack comes 2 cycles after Div_Load.

## Configuration
- CLOCK_ENABLE_SYNC_EN defined:
  - The Sync port exists.
  - Sync=1 in RUN clears all channel counters on the next edge, and Ena=0 in that cycle.
  - Every pending divisor is applied at the same edge, with one Div_Ack on the following cycle.
  - Sync then re-aligns all channels: Ena[i] next fires D[i] cycles after the Sync edge.
  - Sync in HOLD is ignored.
- CLOCK_ENABLE_SYNC_EN undefined: the Sync port is absent, and the block behaves as if Sync=0.

## Test plan
- Reset with POWERUP_CYCLES=16, release at edge 10 → Rec_Reset=1 through edge 26, falls after it, Ena=0 throughout HOLD.
- CHANNELS=2, defaults D=2 → in RUN, Ena[0] and Ena[1] are high in cycles 2,4,6,… and never on two consecutive cycles.
- Program channel 1 to 5 in mid-period, while its counter is 0 and D=2 → the old period completes (strobe at cycle 2), Div_Ack on the next cycle, then strobes every 5 cycles. Channel 0 is unaffected.
- Div_Value=0 and 1 on channel 0 → Ena[0] held high continuously. Div_Channel=3 with CHANNELS=2 → ignored, no Div_Ack.
- nReset low for one cycle mid-RUN with a divisor pending → next cycle Rec_Reset=1, Ena=0, D=DEFAULT_DIV, no Div_Ack.
- With CLOCK_ENABLE_SYNC_EN, D={3,4}, Sync pulse at arbitrary phase → both counters zero and Ena=0 that cycle. Ena[0] fires 3 cycles and Ena[1] fires 4 cycles after the Sync edge.

Source files
------------

// File: rtl/clock_enable_generator.sv
// Power-up reset sequencer and per-channel clock-enable strobes.
// Optional macro CLOCK_ENABLE_SYNC_EN adds the Sync phase-align port.
module clock_enable_generator #(
  parameter int CHANNELS       = 2,
  parameter int DIV_WIDTH      = 16,
  parameter int POWERUP_CYCLES = 1024,
  parameter int DEFAULT_DIV    = 2
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic                Div_Load,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] Div_Channel,
  input  logic [DIV_WIDTH-1:0] Div_Value,
  output logic                Div_Ack,
  output logic                Rec_Reset,
  output logic [CHANNELS-1:0] Ena
`ifdef CLOCK_ENABLE_SYNC_EN
  ,
  input  logic                Sync
`endif
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW = DIV_WIDTH;
  localparam int PW = $clog2(POWERUP_CYCLES + 1);
  localparam logic [PW-1:0] PU_DONE = PW'(POWERUP_CYCLES);
  localparam logic [DW-1:0] DEF_DIV = DW'(DEFAULT_DIV);
  localparam logic [CW:0]   CH_LIM  = (CW+1)'(CHANNELS);

  typedef enum logic {HOLD, RUN} state_t;

  state_t state, state_next;

  logic [PW-1:0]       pu_cnt;
  logic [DW-1:0]       div_q  [CHANNELS];
  logic [DW-1:0]       shadow [CHANNELS];
  logic [DW-1:0]       cnt    [CHANNELS];
  logic [DW-1:0]       last   [CHANNELS];
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] load_hit;
  logic [CHANNELS-1:0] copy;
  logic                chan_ok;
  logic                ack_q;
  logic                synced;
  logic                sync_req;
  logic                run;

`ifdef CLOCK_ENABLE_SYNC_EN
  assign sync_req = Sync;
`else
  assign sync_req = 1'b0;
`endif

  assign run       = (state == RUN);
  assign chan_ok   = ({1'b0, Div_Channel} < CH_LIM);
  assign Rec_Reset = (state == HOLD);
  assign Div_Ack   = ack_q;
  // the cycle right after a Sync edge is forced quiet even for D<=1
  assign Ena       = wrap & ~{CHANNELS{synced}};

  // state register
  always_ff @(posedge Clk) begin
    if (!nReset) state <= HOLD;
    else         state <= state_next;
  end

  // leave HOLD once the power-up count is reached
  always_comb begin
    state_next = state;
    unique case (state)
      HOLD:    if (pu_cnt == PU_DONE) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = HOLD;
    endcase
  end

  // per-channel wrap point, load decode and divisor-copy decision
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      last[i]     = (div_q[i] > DW'(1)) ? div_q[i] - DW'(1) : '0;
      wrap[i]     = run && (cnt[i] == last[i]);
      load_hit[i] = Div_Load && chan_ok && (Div_Channel == CW'(i));
      copy[i]     = pending[i] && !load_hit[i]
                    && (!run || wrap[i] || sync_req);
    end
  end

  // power-up counter, channel counters, divisors and ack
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      pu_cnt  <= '0;
      ack_q   <= 1'b0;
      synced  <= 1'b0;
      pending <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i]  <= DEF_DIV;
        shadow[i] <= DEF_DIV;
        cnt[i]    <= '0;
      end
    end else begin
      if (!run && pu_cnt != PU_DONE) pu_cnt <= pu_cnt + PW'(1);
      ack_q  <= |copy;
      synced <= run && sync_req;
      for (int i = 0; i < CHANNELS; i++) begin
        if (load_hit[i]) begin
          shadow[i]  <= Div_Value;
          pending[i] <= 1'b1;
        end else if (copy[i]) begin
          pending[i] <= 1'b0;
        end
        if (copy[i]) div_q[i] <= shadow[i];
        if (!run || sync_req || wrap[i]) cnt[i] <= '0;
        else                              cnt[i] <= cnt[i] + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_enable_generator.sv
// Scoreboard bench for clock_enable_generator (CHANNELS=3, POWERUP=16).
// Sync checks run only when CLOCK_ENABLE_SYNC_EN is defined.
module tb_clock_enable_generator;

  localparam int CH = 3;
  localparam int DW = 16;
  localparam int PU = 16;

  logic          clk = 1'b0;
  logic          nreset;
  logic          div_load;
  logic [1:0]    div_channel;
  logic [DW-1:0] div_value;
  logic          div_ack;
  logic          rec_reset;
  logic [CH-1:0] ena;
`ifdef CLOCK_ENABLE_SYNC_EN
  logic          sync;
`endif

  logic [4:0] exp_q [$];
  logic [4:0] mon_exp;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clock_enable_generator #(
    .CHANNELS(CH),
    .DIV_WIDTH(DW),
    .POWERUP_CYCLES(PU),
    .DEFAULT_DIV(2)
  ) dut (
    .Clk(clk),
    .nReset(nreset),
    .Div_Load(div_load),
    .Div_Channel(div_channel),
    .Div_Value(div_value),
    .Div_Ack(div_ack),
    .Rec_Reset(rec_reset),
    .Ena(ena)
`ifdef CLOCK_ENABLE_SYNC_EN
    ,
    .Sync(sync)
`endif
  );

  // expected {Rec_Reset, Ena[2:0], Div_Ack} for the current cycle
  task automatic cyc(input logic rr, input logic [2:0] e, input logic a);
    exp_q.push_back({rr, e, a});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_ld(input logic [1:0] ch, input logic [DW-1:0] v,
                        input logic rr, input logic [2:0] e, input logic a);
    div_load    = 1'b1;
    div_channel = ch;
    div_value   = v;
    cyc(rr, e, a);
    div_load    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      total++;
      if ({rec_reset, ena, div_ack} !== mon_exp) begin
        bad++;
        $display("FAIL out#%0d t=%0t got rr/ena/ack=%b exp=%b",
                 total, $time, {rec_reset, ena, div_ack}, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    nreset      = 1'b0;
    div_load    = 1'b0;
    div_channel = '0;
    div_value   = '0;
`ifdef CLOCK_ENABLE_SYNC_EN
    sync        = 1'b0;
`endif
    @(posedge clk);
    #1;
    repeat (2) cyc(1, 3'b000, 0);
    nreset = 1'b1;
    // one cycle before the first high sample plus PU held cycles
    repeat (PU + 1) cyc(1, 3'b000, 0);

    // RUN, all defaults D=2: strobes on even cycles
    for (int c = 1; c <= 6; c++)
      cyc(0, (c % 2 == 0) ? 3'b111 : 3'b000, 0);

    // cycle 7: program ch1=5 while its counter is 0
    cyc_ld(2'd1, 16'd5, 0, 3'b000, 0);
    for (int c = 8; c <= 23; c++)
      cyc(0, {c % 2 == 0,
              (c == 8) || (c >= 13 && (c - 13) % 5 == 0),
              c % 2 == 0}, c == 9);

    // cycle 24: invalid channel 3, ignored
    cyc_ld(2'd3, 16'd7, 0, 3'b101, 0);
    // cycle 25: ch0 <= 0 (continuous), applied at wrap 26, ack 27
    cyc_ld(2'd0, 16'd0, 0, 3'b000, 0);
    cyc(0, 3'b101, 0);
    cyc(0, 3'b001, 1);
    cyc(0, 3'b111, 0);
    // cycle 29: ch0 <= 1 on its own wrap, applied at next wrap, ack 31
    cyc_ld(2'd0, 16'd1, 0, 3'b001, 0);
    for (int c = 30; c <= 34; c++)
      cyc(0, {c % 2 == 0, c == 33, 1'b1}, c == 31);

    // cycles 35,36: ch1 <= 3 then overwritten with 4, one ack at 39
    cyc_ld(2'd1, 16'd3, 0, 3'b001, 0);
    cyc_ld(2'd1, 16'd4, 0, 3'b101, 0);
    for (int c = 37; c <= 46; c++)
      cyc(0, {c % 2 == 0, c == 38 || c == 42 || c == 46, 1'b1}, c == 39);

    // cycle 47: ch2 <= 5 pending; cycle 48: nReset low at its wrap
    cyc_ld(2'd2, 16'd5, 0, 3'b001, 0);
    nreset = 1'b0;
    cyc(0, 3'b101, 0);
    nreset = 1'b1;
    // HOLD again; load ch1=3 at h=3, ack at h=5
    for (int h = 0; h <= PU; h++) begin
      if (h == 3) cyc_ld(2'd1, 16'd3, 1, 3'b000, 0);
      else        cyc(1, 3'b000, h == 5);
    end
    // RUN: ch0/ch2 back to default 2, ch1 = 3
    for (int c = 1; c <= 9; c++)
      cyc(0, {c % 2 == 0, c % 3 == 0, c % 2 == 0}, 0);

`ifdef CLOCK_ENABLE_SYNC_EN
    // cycle 10: ch0 <= 3 on its wrap; cycle 11: ch1 <= 4
    cyc_ld(2'd0, 16'd3, 0, 3'b101, 0);
    cyc_ld(2'd1, 16'd4, 0, 3'b000, 0);
    cyc(0, 3'b111, 0);
    cyc(0, 3'b000, 1);
    cyc(0, 3'b100, 0);
    cyc(0, 3'b001, 0);
    // cycle 16: ch2 <= 1 on its wrap, left pending
    cyc_ld(2'd2, 16'd1, 0, 3'b110, 0);
    // cycle 17: Sync at arbitrary phase
    sync = 1'b1;
    cyc(0, 3'b000, 0);
    sync = 1'b0;
    for (int c = 18; c <= 25; c++)
      cyc(0, {c >= 19, c == 21 || c == 25, c == 20 || c == 23}, c == 18);
`endif

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
